size_seq_ctrl: RTL and testbench

- Command sequencer that drives the size-accumulator block: it generates the clear, add, enable and op-select strobes, plus the wr_size, cmd_extend and s1_flg_384 operands.
- Accepts one command at a time from the SPI command decoder over a valid/ready handshake.
- DATA commands are streamed as length-tagged chunks until the commanded byte count is consumed.
- Reports done/error status back to the decoder.

---
 rtl/size_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_size_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/size_seq_ctrl.sv
// Sequences clear/load/add/extend/hash strobes into the size accumulators; strobes land the cycle after acceptance.
// One command at a time (cmd_ready only in IDLE); DATA chunks are taken whenever chk_ready is high.
module size_seq_ctrl #(
  parameter int LEN_W  = 16,
  parameter int TO_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_type,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_384,
  input  logic             chk_valid,
  output logic             chk_ready,
  input  logic [LEN_W-1:0] chk_len,
  input  logic             abort,
  output logic             size0_clr,
  output logic             size0_add,
  output logic             size1_clr,
  output logic             size1_en,
  output logic [1:0]       size1_op,
  output logic [LEN_W-1:0] wr_size,
  output logic [LEN_W-1:0] cmd_extend,
  output logic             s1_flg_384,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TO_W = $clog2(TO_CYC + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] rem, rem_nx;
  logic [TO_W-1:0]  to_cnt, to_cnt_nx;
  logic [LEN_W-1:0] take;
  logic             cmd_acc, chk_acc;

  logic             size0_clr_nx, size0_add_nx, size1_clr_nx, size1_en_nx;
  logic [1:0]       size1_op_nx;
  logic [LEN_W-1:0] wr_size_nx, cmd_extend_nx;
  logic             s1_flg_384_nx, busy_nx, done_nx, err_nx;

  assign cmd_ready = (state == IDLE) && !abort;
  assign chk_ready = (state == DATA) && !abort;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign chk_acc   = chk_valid && chk_ready;
  // Oversized chunks are clipped to what is left, so rem can never wrap.
  assign take      = (chk_len > rem) ? rem : chk_len;

  always_comb begin
    state_nx      = state;
    rem_nx        = rem;
    to_cnt_nx     = to_cnt;
    size0_clr_nx  = 1'b0;
    size0_add_nx  = 1'b0;
    size1_clr_nx  = 1'b0;
    size1_en_nx   = 1'b0;
    size1_op_nx   = size1_op;
    wr_size_nx    = wr_size;
    cmd_extend_nx = cmd_extend;
    s1_flg_384_nx = s1_flg_384;
    done_nx       = 1'b0;
    err_nx        = err;

    case (state)
      IDLE: begin
        if (cmd_acc) begin
          state_nx = DONE;
          case (cmd_type)
            3'd0: begin
              size0_clr_nx = 1'b1;
              size1_clr_nx = 1'b1;
              err_nx       = 1'b0;
            end
            3'd1: begin
              size1_en_nx = 1'b1;
              size1_op_nx = 2'b00;
              wr_size_nx  = cmd_len;
            end
            3'd2: begin
              rem_nx    = cmd_len;
              to_cnt_nx = '0;
              if (cmd_len != '0) state_nx = DATA;
            end
            3'd3: begin
              size1_en_nx   = 1'b1;
              size1_op_nx   = 2'b10;
              cmd_extend_nx = cmd_len;
            end
            3'd4: begin
              size1_en_nx   = 1'b1;
              size1_op_nx   = 2'b11;
              s1_flg_384_nx = cmd_384;
            end
            default: err_nx = 1'b1;
          endcase
        end
      end

      DATA: begin
        if (abort) begin
          state_nx  = IDLE;
          err_nx    = 1'b1;
          to_cnt_nx = '0;
        end else if (chk_acc) begin
          to_cnt_nx = '0;
          rem_nx    = rem - take;
          if (chk_len > rem) err_nx = 1'b1;
          if (take != '0) begin
            size0_add_nx = 1'b1;
            size1_en_nx  = 1'b1;
            size1_op_nx  = 2'b01;
            wr_size_nx   = take;
          end
          if (rem == take) state_nx = DONE;
        end else if (TO_CYC != 0) begin
          if (to_cnt == TO_W'(TO_CYC - 1)) begin
            state_nx  = DONE;
            err_nx    = 1'b1;
            to_cnt_nx = '0;
          end else begin
            to_cnt_nx = to_cnt + 1'b1;
          end
        end
      end

      DONE: begin
        state_nx = IDLE;
        // An abort landing on the completion cycle swallows the done pulse.
        if (abort) err_nx  = 1'b1;
        else       done_nx = 1'b1;
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      to_cnt     <= '0;
      size0_clr  <= 1'b0;
      size0_add  <= 1'b0;
      size1_clr  <= 1'b0;
      size1_en   <= 1'b0;
      size1_op   <= 2'b00;
      wr_size    <= '0;
      cmd_extend <= '0;
      s1_flg_384 <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      rem        <= rem_nx;
      to_cnt     <= to_cnt_nx;
      size0_clr  <= size0_clr_nx;
      size0_add  <= size0_add_nx;
      size1_clr  <= size1_clr_nx;
      size1_en   <= size1_en_nx;
      size1_op   <= size1_op_nx;
      wr_size    <= wr_size_nx;
      cmd_extend <= cmd_extend_nx;
      s1_flg_384 <= s1_flg_384_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_size_seq_ctrl.sv
// Randomized bench for size_seq_ctrl: a transaction-level model predicts strobe events, err and operand values.
module tb_size_seq_ctrl;
  localparam int LEN_W  = 16;
  localparam int TO_CYC = 8;

  logic             clk, rst_n;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_type;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_384;
  logic             chk_valid, chk_ready;
  logic [LEN_W-1:0] chk_len;
  logic             abort;
  logic             size0_clr, size0_add, size1_clr, size1_en;
  logic [1:0]       size1_op;
  logic [LEN_W-1:0] wr_size, cmd_extend;
  logic             s1_flg_384, busy, done, err;

  size_seq_ctrl #(.LEN_W(LEN_W), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_384(cmd_384),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_len(chk_len),
    .abort(abort),
    .size0_clr(size0_clr), .size0_add(size0_add), .size1_clr(size1_clr), .size1_en(size1_en),
    .size1_op(size1_op), .wr_size(wr_size), .cmd_extend(cmd_extend),
    .s1_flg_384(s1_flg_384), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event record: kind 1=clear pair, 2=size1 update, 3=data add, 15=illegal strobe mix.
  function automatic logic [31:0] ev(input int k, input int op, input int v);
    return {k[7:0], op[7:0], v[15:0]};
  endfunction

  logic [31:0] ev_q[$];
  int          done_cnt, done_cyc, last_strb_cyc;
  int          bad_combo = 0;
  int          rdy_in_strobe = 0;
  logic [3:0]  strb;
  int          en_val;

  always @(negedge clk) begin
    if (rst_n) begin
      strb = {size0_clr, size1_clr, size0_add, size1_en};
      if (strb != 4'b0000) begin
        last_strb_cyc = cyc;
        if (cmd_ready) rdy_in_strobe++;
        case (strb)
          4'b1100: ev_q.push_back(ev(1, 0, 0));
          4'b0011: ev_q.push_back(ev(3, size1_op, wr_size));
          4'b0001: begin
            en_val = (size1_op == 2'b10) ? int'(cmd_extend) :
                     (size1_op == 2'b11) ? int'(s1_flg_384) : int'(wr_size);
            ev_q.push_back(ev(2, size1_op, en_val));
          end
          default: begin
            bad_combo++;
            ev_q.push_back(ev(15, 0, 0));
          end
        endcase
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference state: what the accumulator-facing outputs should hold.
  logic        m_err, m_flg;
  logic [15:0] m_wr, m_ext;
  int          chunk_q[$];

  task automatic send_cmd(input logic [2:0] t, input logic [15:0] len, input logic c384,
                          output int acc);
    int n;
    cmd_type  = t;
    cmd_len   = len;
    cmd_384   = c384;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc = cyc - 1;
  endtask

  task automatic feed_chunk(input int len);
    int n;
    chk_valid = 1'b1;
    chk_len   = 16'(len);
    n = 0;
    @(negedge clk);
    while (!chk_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!chk_ready) check("chk_ready_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] t, input logic [15:0] len, input logic c384);
    logic [31:0] exp_q[$];
    int rem, k, n, take, acc;
    bit tmo_exp;
    exp_q.delete();
    ev_q.delete();
    done_cnt = 0;
    tmo_exp  = 1'b0;
    k        = 0;
    case (t)
      3'd0: begin exp_q.push_back(ev(1, 0, 0)); m_err = 1'b0; end
      3'd1: begin exp_q.push_back(ev(2, 0, len)); m_wr = len; end
      3'd3: begin exp_q.push_back(ev(2, 2, len)); m_ext = len; end
      3'd4: begin exp_q.push_back(ev(2, 3, c384)); m_flg = c384; end
      3'd2: begin
        rem = len;
        while (rem > 0 && k < chunk_q.size()) begin
          take = (chunk_q[k] > rem) ? rem : chunk_q[k];
          if (chunk_q[k] > rem) m_err = 1'b1;
          if (take > 0) begin
            exp_q.push_back(ev(3, 1, take));
            m_wr = 16'(take);
          end
          rem -= take;
          k++;
        end
        if (rem > 0) begin
          tmo_exp = 1'b1;
          m_err   = 1'b1;
        end
      end
      default: m_err = 1'b1;
    endcase

    send_cmd(t, len, c384, acc);
    for (int i = 0; i < k; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      feed_chunk(chunk_q[i]);
    end
    n = 0;
    while (done_cnt == 0 && n < TO_CYC + 30) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);

    check("ev_count", 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check($sformatf("ev%0d_t%0d", i, t), ev_q[i], exp_q[i]);
    check("done_pulses", 32'(done_cnt), 32'd1);
    if (exp_q.size() > 0)   check("done_after_strobe", 32'(done_cyc - last_strb_cyc), 32'd1);
    else if (tmo_exp)       check("timeout_latency", 32'(done_cyc - acc), 32'(TO_CYC + 2));
    else                    check("done_latency", 32'(done_cyc - acc), 32'd2);
    check("err", 32'(err), 32'(m_err));
    check("wr_size", 32'(wr_size), 32'(m_wr));
    check("cmd_extend", 32'(cmd_extend), 32'(m_ext));
    check("s1_flg_384", 32'(s1_flg_384), 32'(m_flg));
    check("busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, 32'({size0_clr, size0_add, size1_clr, size1_en, size1_op}), 32'd0);
    check({tag, "_flags"}, 32'({busy, done, err, s1_flg_384}), 32'd0);
    check({tag, "_wr_size"}, 32'(wr_size), 32'd0);
    check({tag, "_cmd_extend"}, 32'(cmd_extend), 32'd0);
  endtask

  initial begin
    int acc, sum, c, len;
    logic [2:0] t;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_len = '0; cmd_384 = 1'b0;
    chk_valid = 1'b0; chk_len = '0; abort = 1'b0;
    m_err = 1'b0; m_flg = 1'b0; m_wr = '0; m_ext = '0;
    done_cnt = 0; done_cyc = 0; last_strb_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chunk_q.delete();
    do_cmd(3'd0, 16'h0000, 1'b0);
    do_cmd(3'd1, 16'h0100, 1'b0);

    chunk_q = '{40, 40, 20};
    do_cmd(3'd2, 16'd100, 1'b0);
    chunk_q = '{30, 30};
    do_cmd(3'd2, 16'd50, 1'b0);
    chunk_q.delete();
    do_cmd(3'd0, 16'h0000, 1'b0);

    do_cmd(3'd3, 16'h1234, 1'b0);
    do_cmd(3'd4, 16'h0000, 1'b1);
    do_cmd(3'd4, 16'h0000, 1'b0);

    do_cmd(3'd2, 16'd64, 1'b0);
    do_cmd(3'd2, 16'd0, 1'b0);
    do_cmd(3'd6, 16'h00ff, 1'b0);
    do_cmd(3'd0, 16'h0000, 1'b0);

    for (int r = 0; r < 40; r++) begin
      t = 3'($urandom_range(0, 7));
      chunk_q.delete();
      if (t == 3'd2) begin
        len = $urandom_range(0, 150);
        sum = 0;
        while (sum < len) begin
          c = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
          chunk_q.push_back(c);
          sum += c;
        end
      end else begin
        len = $urandom_range(0, 65535);
      end
      do_cmd(t, 16'(len), 1'($urandom_range(0, 1)));
    end

    // Abort one chunk into a DATA command; a chunk offered alongside must be refused.
    ev_q.delete();
    done_cnt = 0;
    send_cmd(3'd2, 16'd100, 1'b0, acc);
    feed_chunk(40);
    abort = 1'b1; chk_valid = 1'b1; chk_len = 16'd10;
    @(negedge clk);
    check("abort_chk_ready", 32'(chk_ready), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    abort = 1'b0; chk_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    m_err = 1'b1; m_wr = 16'd40;
    check("abort_ev_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() > 0) check("abort_ev0", ev_q[0], ev(3, 1, 40));
    check("abort_done", 32'(done_cnt), 32'd0);
    check("abort_err", 32'(err), 32'(m_err));
    @(posedge clk);
    #1;

    // Make sure extend/flag are nonzero before the mid-command reset.
    do_cmd(3'd3, 16'hbeef, 1'b0);
    do_cmd(3'd4, 16'h0000, 1'b1);
    ev_q.delete();
    done_cnt = 0;
    send_cmd(3'd2, 16'd100, 1'b0, acc);
    feed_chunk(30);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_err = 1'b0; m_wr = '0; m_ext = '0; m_flg = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset_ev_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() > 0) check("midreset_ev0", ev_q[0], ev(3, 1, 30));
    check("midreset_done", 32'(done_cnt), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    do_cmd(3'd1, 16'h0042, 1'b0);

    check("strobe_mix", 32'(bad_combo), 32'd0);
    check("cmd_ready_in_strobe", 32'(rdy_in_strobe), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
